reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback stage for the reduced RISC-V core. It is the producer end of the register file write port.
- Merges single-cycle ALU results with handshaked results from the multi-cycle load unit.
- Buffers load results in a small queue and drives a registered write port (we3/ad3/wd3).
- Keeps a scoreboard of outstanding load destinations, which decode uses to stall reads of registers not yet written.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- LQ_DEPTH, 2, load-result queue depth (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
- ld_issue_rd  in  ADDR_W  destination of issued load
- ld_valid  in  1  load result offered
- ld_ready  out  1  queue can accept a load result
- ld_rd  in  ADDR_W  load result destination
- ld_data  in  DATA_W  load result data
- chk_ad1, chk_ad2, chk_rd  in  ADDR_W  decode's source and destination registers
- hazard  out  1  decode must stall
- we3  out  1  register file write enable (registered)
- ad3  out  ADDR_W  write address (registered)
- wd3  out  DATA_W  write data (registered)
- busy  out  1  queue non-empty or any scoreboard bit set

## Operation
- Load queue: FIFO of LQ_DEPTH entries {rd, data}. Push on ld_valid && ld_ready.
- ld_ready = (count < LQ_DEPTH). A pop in the same cycle does not grant extra credit.
- Write arbitration at each rising edge:
  - If alu_valid: the output register loads the ALU result.
  - Else if the queue is non-empty: pop the head and load it.
  - Else: we3 ← 0.
  - ALU always wins.
- Push and pop in the same cycle is legal.
- x0: any write with rd == 0 is performed as we3 = 0, ad3/wd3 = 0. A popped x0 load still counts as committed.
- Scoreboard: 32-bit pending vector.
  - Set: on ld_issue with ld_issue_rd ≠ 0.
  - Clear: on the edge where a popped load for that rd drives we3. Clears are keyed by the popped rd.
  - Simultaneous set and clear of the same bit: set wins.
  - Bit 0 is always 0.
- hazard = pending[chk_ad1] | pending[chk_ad2] | pending[chk_rd]. This combinational output covers RAW and WAW.
- The core must not issue a load to a pending rd. Such an issue is a protocol violation: the bit stays set, with no count.

## Timing
- Reset values: we3=0, ad3=0, wd3=0, ld_ready=1, hazard=0, busy=0, queue empty, pending all 0.
- ALU latency: alu_valid sampled at edge N → we3 high during cycle N..N+1. The register file captures it at edge N+1.
- Load latency: minimum 2 edges (enqueue at N, pop at N+1) when no ALU traffic.
- Load starvation: a load waits while alu_valid stays high. The load unit sees backpressure only when the queue is full.
- Pending bit clears at the pop edge. hazard drops in the cycle we3 is asserted for that register.
- Reset mid-operation: queued results and pending bits are discarded immediately. No write is issued after reset.

## Configuration
- REG_WB_FWD_EN defined:
  - Adds outputs fwd1_en, fwd2_en (1 bit) and fwd_data (DATA_W).
  - fwdN_en = we3 && ad3 ≠ 0 && ad3 == chk_adN; fwd_data = wd3.
  - The scoreboard term for a forwarded source is masked from hazard, which removes the stall in the commit cycle.
- Not defined: no forwarding ports. hazard behaves as stated above.

## Structure
- Package reg_wb_pkg:
  - DATA_W/ADDR_W defaults.
  - Typedef wb_entry_t {rd, data}.
  - Typedef pending_t (32-bit vector).
- Sub-module reg_wb_fifo:
  - Parameterised on depth and entry type.
  - Provides push/pop/count/full/empty.
  - Pointer wrap uses modulo-LQ_DEPTH counters.

## Test plan
- ALU only: alu_valid, rd=5, data=0x12345678 at edge 1 → we3=1, ad3=5, wd3=0x12345678 in the following cycle; we3=0 after.
- Load path: ld_issue rd=7 → hazard with chk_ad1=7. ld_valid rd=7, data=0xCAFEF00D → commit 2 edges later; hazard drops in the commit cycle; pending[7]=0.
- Contention: alu_valid held 4 cycles while two loads arrive → ld_ready=0 after 2 pushes; loads commit in order right after the ALU burst; no load lost.
- x0: ALU write to rd=0 → we3=0. Load issue/result to rd=0 → no hazard, no write, busy returns to 0.
- Simultaneous: the pop of rd=9 coincides with a new ld_issue rd=9 → pending[9] stays 1.
- Reset asserted with queue full and 3 pending bits → all outputs at reset values asynchronously; no write after deassert.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared types for the writeback stage (reg_writeback).
package reg_wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // One buffered load result: destination register and its value.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // One pending bit per architectural register.
  typedef logic [31:0] pending_t;

  // Source selected for the write port at the next edge.
  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LD
  } wb_src_e;

endpackage

// File: rtl/reg_wb_fifo.sv
// reg_wb_fifo: small FIFO holding load results for the writeback stage.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: register-file write port producer. Merges ALU results
// (priority) with queued load results and tracks pending load destinations.
// Optional feature macro: REG_WB_FWD_EN adds write-port forwarding outputs.
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] chk_ad1,
  input  logic [ADDR_W-1:0] chk_ad2,
  input  logic [ADDR_W-1:0] chk_rd,
  output logic              hazard,
  output logic              we3,
  output logic [ADDR_W-1:0] ad3,
  output logic [DATA_W-1:0] wd3,
`ifdef REG_WB_FWD_EN
  output logic              fwd1_en,
  output logic              fwd2_en,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              busy
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);

  entry_t            push_entry;
  entry_t            head;
  logic              push;
  logic              pop;
  logic              lq_full;
  logic              lq_empty;
  logic [CNT_W-1:0]  lq_count;
  wb_src_e           src;
  pending_t          pending;
  pending_t          pending_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] ad_nxt;
  logic [DATA_W-1:0] wd_nxt;

  // Credit is based on current occupancy only; a same-cycle pop does not help.
  assign ld_ready   = !lq_full;
  assign push       = ld_valid && ld_ready;
  assign push_entry = '{rd: ld_rd, data: ld_data};

  reg_wb_fifo #(
    .DEPTH   (LQ_DEPTH),
    .entry_t (entry_t)
  ) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  // Arbitration: ALU always wins, otherwise drain the load queue.
  always_comb begin
    src = WB_SRC_NONE;
    pop = 1'b0;
    if (alu_valid) begin
      src = WB_SRC_ALU;
    end else if (!lq_empty) begin
      src = WB_SRC_LD;
      pop = 1'b1;
    end
  end

  // Next write-port value; writes to x0 become an idle port.
  always_comb begin
    we_nxt = 1'b0;
    ad_nxt = '0;
    wd_nxt = '0;
    unique case (src)
      WB_SRC_ALU: begin
        if (alu_rd != '0) begin
          we_nxt = 1'b1;
          ad_nxt = alu_rd;
          wd_nxt = alu_data;
        end
      end
      WB_SRC_LD: begin
        if (head.rd != '0) begin
          we_nxt = 1'b1;
          ad_nxt = head.rd;
          wd_nxt = head.data;
        end
      end
      default: ;
    endcase
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      ad3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= we_nxt;
      ad3 <= ad_nxt;
      wd3 <= wd_nxt;
    end
  end

  // Scoreboard update: clear on pop, then set on issue so a new issue wins.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head.rd] = 1'b0;
    if (ld_issue) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

`ifdef REG_WB_FWD_EN
  assign fwd1_en  = we3 && (ad3 != '0) && (ad3 == chk_ad1);
  assign fwd2_en  = we3 && (ad3 != '0) && (ad3 == chk_ad2);
  assign fwd_data = wd3;
  assign hazard   = (pending[chk_ad1] & ~fwd1_en) |
                    (pending[chk_ad2] & ~fwd2_en) |
                    pending[chk_rd];
`else
  assign hazard   = pending[chk_ad1] | pending[chk_ad2] | pending[chk_rd];
`endif

  assign busy = (lq_count != '0) || (pending != '0);

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: scoreboard bench for reg_writeback with a queue-based
// reference model of the writeback rules.
module tb_reg_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  chk_ad1, chk_ad2, chk_rd;
  logic        hazard;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic        busy;
`ifdef REG_WB_FWD_EN
  logic        fwd1_en, fwd2_en;
  logic [31:0] fwd_data;
`endif

  reg_writeback #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .chk_ad1(chk_ad1), .chk_ad2(chk_ad2), .chk_rd(chk_rd),
    .hazard(hazard), .we3(we3), .ad3(ad3), .wd3(wd3),
`ifdef REG_WB_FWD_EN
    .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd_data(fwd_data),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [4:0]  ad;
    logic [31:0] wd;
  } wr_t;

  // Reference model state
  wr_t         exp_q[$];
  int          mq_rd[$];
  logic [31:0] mq_data[$];
  bit   [31:0] pend;
  wr_t         last_wr;
  int          outstanding[$];

  int checks = 0;
  int failures = 0;
  bit acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cr);
    bit h1, h2;
    h1 = pend[c1];
    h2 = pend[c2];
`ifdef REG_WB_FWD_EN
    if (last_wr.we && last_wr.ad == c1) h1 = 1'b0;
    if (last_wr.we && last_wr.ad == c2) h2 = 1'b0;
`endif
    return h1 | h2 | pend[cr];
  endfunction

  // Apply one cycle of inputs, check combinational outputs, predict the edge.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                      input bit iss, input logic [4:0] ird,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cr,
                      output bit accepted);
    wr_t w;
    bit rdy;
    int r;
    logic [31:0] d;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_issue = iss; ld_issue_rd = ird;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    chk_ad1 = c1; chk_ad2 = c2; chk_rd = cr;
    #1;
    rdy = (mq_rd.size() < DEPTH);
    chk("ld_ready", ld_ready, rdy);
    chk("hazard", hazard, model_hazard(c1, c2, cr));
    chk("busy", busy, (mq_rd.size() != 0) || (pend != 0));
    w = '{we: 1'b0, ad: 5'd0, wd: 32'd0};
    if (av) begin
      if (ard != 0) w = '{we: 1'b1, ad: ard, wd: adat};
    end else if (mq_rd.size() > 0) begin
      r = mq_rd.pop_front();
      d = mq_data.pop_front();
      pend[r] = 1'b0;
      if (r != 0) w = '{we: 1'b1, ad: 5'(r), wd: d};
    end
    if (iss && ird != 0) pend[ird] = 1'b1;
    accepted = lv && rdy;
    if (accepted) begin
      mq_rd.push_back(int'(lrd));
      mq_data.push_back(ldat);
    end
    exp_q.push_back(w);
    last_wr = w;
  endtask

  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit iss, input logic [4:0] ird,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cr,
                       output bit accepted);
    @(negedge clk);
    step(av, ard, adat, iss, ird, lv, lrd, ldat, c1, c2, cr, accepted);
  endtask

  task automatic idle(input int n, input logic [4:0] c1);
    bit a;
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, c1, 0, 0, a);
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic do_reset(input logic [4:0] c);
    bit a;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_ad3", ad3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_hazard", hazard, 0);
    chk("rst_busy", busy, 0);
    alu_valid = 0; ld_issue = 0; ld_valid = 0;
    mq_rd.delete(); mq_data.delete(); outstanding.delete();
    pend = '0;
    last_wr = '{we: 1'b0, ad: 5'd0, wd: 32'd0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, c, 0, 0, a);
  endtask

  // Monitor: compare the write port after every edge with the predicted write.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("we3", we3, e.we);
        chk("ad3", ad3, e.ad);
        chk("wd3", wd3, e.wd);
      end
    end
  end

  initial begin
    bit lv, iss;
    logic [4:0] lrd, ird;
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    chk_ad1 = 0; chk_ad2 = 0; chk_rd = 0;
    pend = '0;
    last_wr = '{we: 1'b0, ad: 5'd0, wd: 32'd0};

    do_reset(0);

    // ALU only
    cycle(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 5, 0, 0, acc);
    idle(2, 5);

    // Load path
    cycle(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 7, 32'hCAFEF00D, 7, 0, 0, acc);
    idle(3, 7);

    // Contention: ALU burst while loads arrive
    cycle(0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, acc);
    cycle(1, 1, 32'h11111111, 0, 0, 1, 10, 32'hA0A0A0A0, 0, 10, 0, acc);
    cycle(1, 2, 32'h22222222, 0, 0, 1, 11, 32'hA1A1A1A1, 0, 0, 11, acc);
    cycle(1, 3, 32'h33333333, 0, 0, 1, 12, 32'hA2A2A2A2, 12, 0, 0, acc);
    cycle(1, 4, 32'h44444444, 0, 0, 0, 0, 0, 10, 11, 12, acc);
    idle(4, 10);
    cycle(0, 0, 0, 0, 0, 1, 12, 32'hA2A2A2A2, 12, 0, 0, acc);
    idle(3, 12);

    // x0 handling
    cycle(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h0BADF00D, 0, 0, 0, acc);
    idle(3, 0);

    // Pop of rd=9 coincides with a new issue to rd=9
    cycle(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 1, 9, 32'h99990000, 9, 0, 0, acc);
    cycle(0, 0, 0, 1, 9, 0, 0, 0, 9, 0, 0, acc);
    idle(2, 9);
    cycle(0, 0, 0, 0, 0, 1, 9, 32'h99991111, 9, 0, 0, acc);
    idle(3, 9);

    // Reset with a full queue and three pending bits
    cycle(0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 1, 21, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 1, 22, 0, 0, 0, 0, 0, 0, acc);
    cycle(1, 3, 32'h30303030, 0, 0, 1, 20, 32'h20202020, 20, 0, 0, acc);
    cycle(1, 4, 32'h40404040, 0, 0, 1, 21, 32'h21212121, 21, 0, 0, acc);
    cycle(1, 5, 32'h50505050, 0, 0, 0, 0, 0, 22, 0, 0, acc);
    do_reset(20);
    idle(4, 20);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset(5'($urandom_range(0, 31)));
      lv  = (outstanding.size() > 0) && ($urandom_range(0, 1) == 1);
      lrd = lv ? 5'(outstanding[0]) : 5'($urandom_range(0, 31));
      ird = 5'($urandom_range(0, 31));
      iss = ($urandom_range(0, 2) == 0) && !pend[ird] && (outstanding.size() < 4);
      cycle($urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), $urandom,
            iss, ird, lv, lrd, $urandom,
            ($urandom_range(0, 1) == 1) ? ird : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), acc);
      if (acc) void'(outstanding.pop_front());
      if (iss) outstanding.push_back(int'(ird));
    end
    idle(8, 0);

    @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
